// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The master side plays CPU fetch stage plus instruction memory; the slave side is the cache.
interface icache_direct_mapped_if;
  logic         cpu_read;
  logic [31:0]  cpu_address;
  logic [31:0]  cpu_readdata;
  logic         cpu_busywait;
  logic         flush;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport master (
    output cpu_read, cpu_address, flush, mem_readdata, mem_busywait,
    input  cpu_readdata, cpu_busywait, mem_read, mem_address
  );

  modport slave (
    input  cpu_read, cpu_address, flush, mem_readdata, mem_busywait,
    output cpu_readdata, cpu_busywait, mem_read, mem_address
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 16-byte block refills
// via a three-state fill FSM, and a flush that invalidates every line.
module icache_direct_mapped #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  icache_direct_mapped_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                  state_reg, state_next;
  logic [LINES-1:0]        valid_reg, valid_next;
  logic                    flush_pend_reg, flush_pend_next;
  logic [27:0]             fill_addr_reg, fill_addr_next;

  logic [127:0]            data_mem [LINES];
  logic [TAG_BITS-1:0]     tag_mem  [LINES];

  logic [INDEX_BITS-1:0]   cpu_index;
  logic [TAG_BITS-1:0]     cpu_tag;
  logic [INDEX_BITS-1:0]   fill_index;
  logic [TAG_BITS-1:0]     fill_tag;
  logic [127:0]            line_data;
  logic [31:0]             line_words [4];
  logic                    hit;
  logic                    flush_clear;
  logic                    install;
  logic                    load_addr;
  logic                    unused_addr_bits;

  assign cpu_index        = bus.cpu_address[4 +: INDEX_BITS];
  assign cpu_tag          = bus.cpu_address[31 -: TAG_BITS];
  assign fill_index       = fill_addr_reg[INDEX_BITS-1:0];
  assign fill_tag         = fill_addr_reg[27 -: TAG_BITS];
  assign unused_addr_bits = ^bus.cpu_address[1:0];

  assign line_data = data_mem[cpu_index];
  assign hit       = valid_reg[cpu_index] && (tag_mem[cpu_index] == cpu_tag);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign line_words[gi] = line_data[32*gi +: 32];
    end
  endgenerate

  // Gated by hit so the output reads 0 while arrays are uninitialised or the line is stale.
  assign bus.cpu_readdata = hit ? line_words[bus.cpu_address[3:2]] : 32'd0;

  // A flush seen in IDLE (fresh pulse or one parked during a fill) wins over any hit.
  assign flush_clear = (state_reg == IDLE) && (bus.flush || flush_pend_reg);
  assign install     = (state_reg == UPDATE);

  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      assign valid_next[gi] = flush_clear ? 1'b0 :
                              (install && fill_index == INDEX_BITS'(gi)) ? 1'b1 :
                              valid_reg[gi];
    end
  endgenerate

  always_comb begin
    flush_pend_next = flush_pend_reg;
    if (flush_clear) begin
      flush_pend_next = 1'b0;
    end else if (bus.flush) begin
      flush_pend_next = 1'b1;
    end
  end

  assign fill_addr_next = load_addr ? bus.cpu_address[31:4] : fill_addr_reg;

  always_comb begin
    state_next       = state_reg;
    bus.cpu_busywait = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_address  = 28'd0;
    load_addr        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.flush || flush_pend_reg) begin
          bus.cpu_busywait = 1'b1;
        end else if (bus.cpu_read && !hit) begin
          bus.cpu_busywait = 1'b1;
          load_addr        = 1'b1;
          state_next       = MEM_READ;
        end
      end
      MEM_READ: begin
        bus.mem_read     = 1'b1;
        bus.mem_address  = fill_addr_reg;
        bus.cpu_busywait = 1'b1;
        if (!bus.mem_busywait) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        // Block is sampled a cycle after mem_busywait falls so the last byte has settled.
        bus.cpu_busywait = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      flush_pend_reg <= 1'b0;
      fill_addr_reg  <= 28'd0;
    end else begin
      state_reg      <= state_next;
      valid_reg      <= valid_next;
      flush_pend_reg <= flush_pend_next;
      fill_addr_reg  <= fill_addr_next;
    end
  end

  // Data and tag storage carries no reset; validity alone decides whether a line is usable.
  always_ff @(posedge clock) begin
    if (install) begin
      data_mem[fill_index] <= bus.mem_readdata;
      tag_mem[fill_index]  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: vector table applied through a
// scoreboard, plus hand-written reset sequences.
module tb_icache_direct_mapped;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  icache_direct_mapped_if bus ();

  icache_direct_mapped #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: block data is a function of block address; 16 cycles per fill.
  function automatic logic [127:0] blk(input logic [27:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) begin
      if (b == 28'd0 && w == 0) r[32*w +: 32] = 32'h0010_0263;
      else                      r[32*w +: 32] = {4'hA, b[23:0], 2'b00, 2'(w)};
    end
    return r;
  endfunction

  int          mem_cnt;
  logic [27:0] mem_blk;
  initial begin
    mem_cnt = 0;
    mem_blk = 28'd0;
  end
  always @(posedge clk) begin
    if (bus.mem_read) begin
      mem_cnt <= mem_cnt + 1;
      mem_blk <= bus.mem_address;
    end else begin
      mem_cnt <= 0;
    end
  end
  assign bus.mem_busywait = !(bus.mem_read && mem_cnt == 15);
  assign bus.mem_readdata = blk(mem_blk);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stalls;
    int          mcyc;
    int          flush_at;   // -1 none, 0 with request, k: after k-th stall
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          stalls;
    int          mcyc;
    logic [27:0] maddr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    exp_t        got;
    logic [127:0] b;
    logic [31:0] addr_l;
    int          stalls;
    int          mcyc;
    logic [27:0] maddr;
    bool_t_dummy: begin end
    addr_l   = v.addr;
    b        = blk(addr_l[31:4]);
    e.data   = b[32*addr_l[3:2] +: 32];
    e.stalls = v.stalls;
    e.mcyc   = v.mcyc;
    e.maddr  = (v.mcyc > 0) ? addr_l[31:4] : 28'd0;
    sb.push_back(e);

    @(negedge clk);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = v.addr;
    if (v.flush_at == 0) bus.flush = 1'b1;
    stalls = 0;
    mcyc   = 0;
    maddr  = 28'd0;
    forever begin
      #1;
      if (!bus.cpu_busywait) break;
      stalls++;
      if (bus.mem_read) begin
        if (mcyc == 0) maddr = bus.mem_address;
        mcyc++;
      end
      if (stalls > 200) begin
        errors++;
        $display("FAIL vec%0d timeout: busywait still high after %0d cycles", idx, stalls);
        break;
      end
      if (stalls == v.flush_at) bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
    end
    bus.flush = 1'b0;

    got = sb.pop_front();
    check($sformatf("vec%0d data", idx),   64'(bus.cpu_readdata), 64'(got.data));
    check($sformatf("vec%0d stalls", idx), 64'(stalls),           64'(got.stalls));
    check($sformatf("vec%0d memcyc", idx), 64'(mcyc),             64'(got.mcyc));
    check($sformatf("vec%0d maddr", idx),  64'(maddr),            64'(got.maddr));
    $display("vec%0d addr=%h data=%h stalls=%0d memcyc=%0d maddr=%h",
             idx, v.addr, bus.cpu_readdata, stalls, mcyc, maddr);
  endtask

  initial begin
    int guard;
    int seen;

    vecs[0]  = '{32'h0000_0000, 18, 16, -1};  // cold miss
    vecs[1]  = '{32'h0000_0004,  0,  0, -1};  // hit word 1
    vecs[2]  = '{32'h0000_000C,  0,  0, -1};  // hit word 3
    vecs[3]  = '{32'h0000_0080, 18, 16, -1};  // conflict miss, index 0 tag 1
    vecs[4]  = '{32'h0000_0000, 18, 16, -1};  // evicted, misses again
    vecs[5]  = '{32'h0000_0014, 18, 16, -1};  // index 1 miss
    vecs[6]  = '{32'h0000_0018,  0,  0, -1};  // index 1 hit
    vecs[7]  = '{32'h0000_0004, 19, 16,  0};  // flush with hit: 1 stall then refill
    vecs[8]  = '{32'h0000_002C, 37, 32,  5};  // flush mid-fill: install, clear, refill
    vecs[9]  = '{32'h0000_002C,  0,  0, -1};  // hit after refill
    vecs[10] = '{32'h0000_0000, 18, 16, -1};  // after mid-fill reset: miss
    vecs[11] = '{32'h0000_0040, 18, 16, -1};  // interrupted line was never validated

    rst_n           = 1'b0;
    bus.cpu_read    = 1'b0;
    bus.cpu_address = 32'd0;
    bus.flush       = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset mem_read",     64'(bus.mem_read),     64'd0);
    check("reset mem_address",  64'(bus.mem_address),  64'd0);
    check("reset cpu_busywait", 64'(bus.cpu_busywait), 64'd0);
    check("reset cpu_readdata", 64'(bus.cpu_readdata), 64'd0);
    $display("reset outputs checked");

    @(negedge clk);
    rst_n           = 1'b1;
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 32'd0;
    #1;
    check("post-reset miss busywait", 64'(bus.cpu_busywait), 64'd1);
    bus.cpu_read = 1'b0;
    $display("post-reset read busywait=%0b", bus.cpu_busywait);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset asserted in the middle of a fill.
    @(negedge clk);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 32'h0000_0040;
    seen  = 0;
    guard = 0;
    while (seen < 8 && guard < 50) begin
      #1;
      if (bus.mem_read) seen++;
      guard++;
      @(negedge clk);
    end
    check("midfill mem_read cycles seen", 64'(seen), 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check("midfill reset mem_read",    64'(bus.mem_read),    64'd0);
    check("midfill reset mem_address", 64'(bus.mem_address), 64'd0);
    $display("midfill reset mem_read=%0b mem_address=%h", bus.mem_read, bus.mem_address);
    @(negedge clk);
    @(negedge clk);
    bus.cpu_read = 1'b0;
    rst_n        = 1'b1;

    for (int i = 10; i < 12; i++) run_vec(vecs[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
